// File: rtl/cdc_pkg.sv
// cdc_pkg: shared constants and helpers for clock-domain-crossing blocks.
//   STAGES_MIN / STAGES_MAX : legal synchronizer chain depths
//   FILTER_MAX              : largest supported debounce length
//   filt_cnt_w(n)           : counter width able to hold the value n
package cdc_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MAX = 255;

  // Width of a counter that must reach n (clog2(n+1)).
  function automatic int filt_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_chan.sv
// sync_chan: one synchronized, debounced status channel.
// Ports:
//   dst_clk      destination clock
//   dst_rst      asynchronous active-high reset
//   src_signal   asynchronous input level
//   evt_clear    clears evt_sticky (dst_clk domain)
//   dst_signal   synchronized and filtered level (registered)
//   rise_pulse   one-cycle pulse when dst_signal goes 0->1 (registered)
//   fall_pulse   one-cycle pulse when dst_signal goes 1->0 (registered)
//   event_pulse  rise_pulse | fall_pulse (registered)
//   evt_sticky   latched event flag (registered)
module sync_chan
  import cdc_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter logic RST_BIT       = 1'b0,
  parameter int   FILTER_CYCLES = 1
) (
  input  logic dst_clk,
  input  logic dst_rst,
  input  logic src_signal,
  input  logic evt_clear,
  output logic dst_signal,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_pulse,
  output logic evt_sticky
);

  localparam int               CNT_W    = filt_cnt_w(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_r;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             level_r;
  logic             level_nxt_s;
  logic             sync_s;
  logic             upd_s;
  logic             rise_r;
  logic             fall_r;
  logic             event_r;
  logic             sticky_r;
  logic             sticky_nxt_s;

  assign sync_s = chain_r[STAGES-1];

  // Synchronizer chain: plain shift register, nothing between stages.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      chain_r <= {STAGES{RST_BIT}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], src_signal};
    end
  end

  // Debounce decision: a differing value must persist FILTER_CYCLES cycles;
  // any return to the current level restarts the count.
  always_comb begin
    upd_s        = 1'b0;
    cnt_nxt_s    = CNT_ZERO;
    level_nxt_s  = level_r;
    if (sync_s == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      upd_s     = 1'b1;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
    if (upd_s) begin
      level_nxt_s = sync_s;
    end else begin
      level_nxt_s = level_r;
    end
    // Sticky uses the event being registered this edge, so a clear in the
    // same cycle cannot swallow it.
    sticky_nxt_s = upd_s | (sticky_r & ~evt_clear);
  end

  // Filter state, edge pulses and sticky flag.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      cnt_r    <= CNT_ZERO;
      level_r  <= RST_BIT;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      event_r  <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      level_r  <= level_nxt_s;
      rise_r   <= upd_s & sync_s;
      fall_r   <= upd_s & ~sync_s;
      event_r  <= upd_s;
      sticky_r <= sticky_nxt_s;
    end
  end

  assign dst_signal  = level_r;
  assign rise_pulse  = rise_r;
  assign fall_pulse  = fall_r;
  assign event_pulse = event_r;
  assign evt_sticky  = sticky_r;

endmodule

// File: rtl/sync_nff_filter.sv
// sync_nff_filter: WIDTH independent level synchronizers with debounce,
// registered edge pulses and sticky event capture.
// Ports:
//   dst_clk      destination clock (only clock)
//   dst_rst      asynchronous active-high reset
//   src_signal   [WIDTH] asynchronous inputs, each bit independent
//   evt_clear    [WIDTH] per-channel sticky clear
//   dst_signal   [WIDTH] synchronized, filtered levels
//   rise_pulse   [WIDTH] 0->1 pulses
//   fall_pulse   [WIDTH] 1->0 pulses
//   event_pulse  [WIDTH] any-edge pulses
//   evt_sticky   [WIDTH] latched event flags
module sync_nff_filter
  import cdc_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}},
  parameter int               FILTER_CYCLES = 1
) (
  input  logic             dst_clk,
  input  logic             dst_rst,
  input  logic [WIDTH-1:0] src_signal,
  input  logic [WIDTH-1:0] evt_clear,
  output logic [WIDTH-1:0] dst_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_pulse,
  output logic [WIDTH-1:0] evt_sticky
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_nff_filter: WIDTH must be in 1..32");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_nff_filter: STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
    $error("sync_nff_filter: FILTER_CYCLES must be in 1..255");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chan #(
      .STAGES        (STAGES),
      .RST_BIT       (RST_VAL[i]),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .dst_clk     (dst_clk),
      .dst_rst     (dst_rst),
      .src_signal  (src_signal[i]),
      .evt_clear   (evt_clear[i]),
      .dst_signal  (dst_signal[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .event_pulse (event_pulse[i]),
      .evt_sticky  (evt_sticky[i])
    );
  end

endmodule

// File: tb/tb_sync_nff_filter.sv
module tb_sync_nff_filter;

  localparam int         SA = 2;
  localparam int         FA = 3;
  localparam logic [3:0] RA = 4'b0010;
  localparam int         SB = 4;
  localparam int         FB = 1;
  localparam logic [31:0] RB = 32'h0000_0000;

  logic        dst_clk = 1'b0;
  logic        dst_rst;
  logic [3:0]  src_a, clr_a, dst_a, rise_a, fall_a, ev_a, stk_a;
  logic [31:0] src_b, clr_b, dst_b, rise_b, fall_b, ev_b, stk_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 dst_clk = ~dst_clk;

  sync_nff_filter #(.WIDTH(4), .STAGES(SA), .RST_VAL(RA), .FILTER_CYCLES(FA)) dut_a (
    .dst_clk(dst_clk), .dst_rst(dst_rst), .src_signal(src_a), .evt_clear(clr_a),
    .dst_signal(dst_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .event_pulse(ev_a), .evt_sticky(stk_a));

  sync_nff_filter #(.WIDTH(32), .STAGES(SB), .RST_VAL(RB), .FILTER_CYCLES(FB)) dut_b (
    .dst_clk(dst_clk), .dst_rst(dst_rst), .src_signal(src_b), .evt_clear(clr_b),
    .dst_signal(dst_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .event_pulse(ev_b), .evt_sticky(stk_b));

  wire [179:0] got_all = {dst_a, rise_a, fall_a, ev_a, stk_a,
                          dst_b, rise_b, fall_b, ev_b, stk_b};

  // Reference model: the synchronized value is the source as sampled STAGES-1
  // edges earlier; the output flips when the last FILTER_CYCLES synchronized
  // values all disagreed with it.
  logic [31:0] m_samp [2][4];
  logic [31:0] m_hist [2][4];
  logic [31:0] m_dst [2];
  logic [31:0] m_rise [2];
  logic [31:0] m_fall [2];
  logic [31:0] m_ev [2];
  logic [31:0] m_stk [2];

  function automatic int cfg_s(input int d);
    return (d == 0) ? SA : SB;
  endfunction
  function automatic int cfg_f(input int d);
    return (d == 0) ? FA : FB;
  endfunction
  function automatic logic [31:0] cfg_mask(input int d);
    return (d == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] cfg_rv(input int d);
    return (d == 0) ? {28'h0, RA} : RB;
  endfunction

  function automatic logic [179:0] exp_all();
    return {m_dst[0][3:0], m_rise[0][3:0], m_fall[0][3:0], m_ev[0][3:0], m_stk[0][3:0],
            m_dst[1], m_rise[1], m_fall[1], m_ev[1], m_stk[1]};
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 4; i++) begin
      m_samp[d][i] = cfg_rv(d);
      m_hist[d][i] = cfg_rv(d);
    end
    m_dst[d]  = cfg_rv(d);
    m_rise[d] = 32'h0;
    m_fall[d] = 32'h0;
    m_ev[d]   = 32'h0;
    m_stk[d]  = 32'h0;
  endtask

  task automatic model_step(input int d, input logic [31:0] src, input logic [31:0] clr);
    logic [31:0] chg;
    chg = cfg_mask(d);
    for (int i = 0; i < cfg_f(d); i++) chg = chg & (m_hist[d][i] ^ m_dst[d]);
    m_dst[d]  = m_dst[d] ^ chg;
    m_rise[d] = chg & m_dst[d];
    m_fall[d] = chg & ~m_dst[d];
    m_ev[d]   = chg;
    m_stk[d]  = chg | (m_stk[d] & ~clr);
    for (int i = 3; i > 0; i--) m_samp[d][i] = m_samp[d][i-1];
    m_samp[d][0] = src & cfg_mask(d);
    for (int i = 3; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
    m_hist[d][0] = m_samp[d][cfg_s(d)-1];
  endtask

  // One destination clock edge: advance the model, then settle before sampling.
  task automatic tick();
    @(posedge dst_clk);
    model_step(0, {28'h0, src_a}, {28'h0, clr_a});
    model_step(1, src_b, clr_b);
    #1;
  endtask

  task automatic test_reset();
    dst_rst = 1'b1;
    src_a = RA; clr_a = 4'h0; src_b = 32'h0; clr_b = 32'h0;
    model_reset(0);
    model_reset(1);
    #12;
    n_vec++;
    if (got_all !== {RA, 16'h0, RB, 128'h0}) begin
      n_err++;
      $display("FAIL reset_state: got %h exp %h", got_all, {RA, 16'h0, RB, 128'h0});
    end
    #11 dst_rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      tick();
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL idle_model cyc %0d: got %h exp %h", c, got_all, exp_all());
      end
      n_vec++;
      if ({dst_a, ev_a, stk_a} !== {RA, 8'h00}) begin
        n_err++;
        $display("FAIL idle_hold cyc %0d: got %h exp %h", c, {dst_a, ev_a, stk_a}, {RA, 8'h00});
      end
    end
  endtask

  task automatic test_rise();
    int lat;
    lat = 0;
    src_a[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (dst_a[0] === 1'b1 && lat == 0) lat = e;
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL rise_model edge %0d: got %h exp %h", e, got_all, exp_all());
      end
      n_vec++;
      if ({rise_a[0], ev_a[0]} !== {2{e == SA + FA}}) begin
        n_err++;
        $display("FAIL rise_pulse edge %0d: got %b exp %b", e, {rise_a[0], ev_a[0]}, {2{e == SA + FA}});
      end
    end
    n_vec++;
    if (lat != SA + FA || stk_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rise_latency: got lat %0d sticky %b exp lat %0d sticky 1", lat, stk_a[0], SA + FA);
    end
  endtask

  task automatic test_glitch();
    src_a[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 1) src_a[3] = 1'b0;
      n_vec++;
      if (got_all !== exp_all() || dst_a[3] !== 1'b0 || ev_a[3] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch cyc %0d: got %h exp %h", c, got_all, exp_all());
      end
    end
  endtask

  task automatic test_clear_set_wins();
    bit seen;
    seen = 1'b0;
    clr_a[1] = 1'b1;
    src_a[1] = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      seen = (fall_a[1] === 1'b1);
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL clr_model cyc %0d: got %h exp %h", c, got_all, exp_all());
      end
    end
    n_vec++;
    if (!seen || stk_a[1] !== 1'b1) begin
      n_err++;
      $display("FAIL clr_set_wins: got fall %b sticky %b exp 1 1", seen, stk_a[1]);
    end
    clr_a[1] = 1'b0;
    tick();
    n_vec++;
    if (got_all !== exp_all() || stk_a[1] !== 1'b1 || fall_a[1] !== 1'b0) begin
      n_err++;
      $display("FAIL clr_hold: got %h exp %h", got_all, exp_all());
    end
    clr_a[1] = 1'b1;
    tick();
    clr_a[1] = 1'b0;
    n_vec++;
    if (got_all !== exp_all() || stk_a[1] !== 1'b0) begin
      n_err++;
      $display("FAIL clr_only: got %h exp %h", got_all, exp_all());
    end
  endtask

  task automatic test_async_reset();
    int rcnt [4];
    int fcnt [4];
    for (int i = 0; i < 4; i++) begin rcnt[i] = 0; fcnt[i] = 0; end
    src_a[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL arst_pre cyc %0d: got %h exp %h", c, got_all, exp_all());
      end
    end
    #3 dst_rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    n_vec++;
    if (got_all !== {RA, 16'h0, RB, 128'h0}) begin
      n_err++;
      $display("FAIL arst_immediate: got %h exp %h", got_all, {RA, 16'h0, RB, 128'h0});
    end
    src_a = 4'b1111;
    #2 dst_rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        rcnt[i] += int'(rise_a[i]);
        fcnt[i] += int'(fall_a[i]);
      end
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL arst_model edge %0d: got %h exp %h", e, got_all, exp_all());
      end
      if (e == SA + FA - 1 || e == SA + FA) begin
        n_vec++;
        if (dst_a !== ((e == SA + FA) ? 4'b1111 : RA)) begin
          n_err++;
          $display("FAIL arst_latency edge %0d: got %b exp %b", e, dst_a, (e == SA + FA) ? 4'b1111 : RA);
        end
      end
    end
    n_vec++;
    if ({rcnt[3], rcnt[2], rcnt[1], rcnt[0], fcnt[3], fcnt[2], fcnt[1], fcnt[0]}
        !== {32'd1, 32'd1, 32'd0, 32'd1, 128'd0}) begin
      n_err++;
      $display("FAIL arst_pulse_count: rise %0d%0d%0d%0d fall %0d%0d%0d%0d exp rise 1101 fall 0000",
               rcnt[3], rcnt[2], rcnt[1], rcnt[0], fcnt[3], fcnt[2], fcnt[1], fcnt[0]);
    end
  endtask

  task automatic test_walk();
    int rcnt [32];
    int fcnt [32];
    int tog [32];
    logic [31:0] nxt;
    for (int i = 0; i < 32; i++) begin rcnt[i] = 0; fcnt[i] = 0; tog[i] = 0; end
    for (int k = 0; k <= 32; k++) begin
      nxt = (k < 32) ? (32'h1 << k) : 32'h0;
      for (int i = 0; i < 32; i++) tog[i] += int'(nxt[i] ^ src_b[i]);
      src_b = nxt;
      for (int c = 0; c < ((k < 32) ? 3 : 8); c++) begin
        tick();
        for (int i = 0; i < 32; i++) begin
          rcnt[i] += int'(rise_b[i]);
          fcnt[i] += int'(fall_b[i]);
        end
        n_vec++;
        if (got_all !== exp_all()) begin
          n_err++;
          $display("FAIL walk_model k %0d cyc %0d: got %h exp %h", k, c, got_all, exp_all());
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rcnt[i] + fcnt[i] != tog[i] || rcnt[i] != fcnt[i]) begin
        n_err++;
        $display("FAIL walk_count bit %0d: got rise %0d fall %0d exp toggles %0d", i, rcnt[i], fcnt[i], tog[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) src_a = src_a ^ 4'($urandom);
      clr_a = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 2) == 0) src_b = src_b ^ ($urandom & $urandom);
      clr_b = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'h0;
      tick();
      n_vec++;
      if (got_all !== exp_all()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h exp %h", c, got_all, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_rise();
    test_glitch();
    test_clear_set_wins();
    test_async_reset();
    test_walk();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
